stripes_input_serializer: RTL and testbench

Bit-serial input dispatcher placed directly upstream of the Stripes node slice. It accepts one window of Ti parallel N-bit neurons per handshake from NBin and collects Tw windows into a brick in a ping-pong buffer. It then replays the brick MSB-first, one bit per neuron per cycle, for a programmable precision. It drives the slice's i_inputs, i_first_cycle, i_precision and i_load.

---
 rtl/stripes_input_serializer.sv | 159 +++++++++++++++
 tb/tb_stripes_input_serializer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stripes_input_serializer.sv
// rtl/stripes_input_serializer.sv - ping-pong brick buffer replayed MSB-first as bit-serial neuron streams
module stripes_input_serializer #(
    parameter int N  = 16,
    parameter int Ti = 16,
    parameter int Tw = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [N*Ti-1:0]  i_window,
    input  logic [4:0]       i_precision,
    output logic [Tw*Ti-1:0] o_inputs,
    output logic             o_valid,
    output logic             o_first_cycle,
    output logic [Tw-1:0]    o_load,
    output logic [4:0]       o_precision
);

    localparam int WB = $clog2(Tw);
    localparam int BB = $clog2(N);
    localparam logic [4:0] P_MAX = 5'(N);

    typedef enum logic {IDLE, SERIAL} state_t;

    logic [N-1:0]   mem [2][Tw][Ti];
    logic [1:0]     full;
    logic [4:0]     prec [2];
    logic           wr_sel;
    logic [WB-1:0]  wcnt;
    logic           accept;
    logic           last_win;

    state_t         state, state_nxt;
    logic [4:0]     k, k_nxt;
    logic           rd_sel, rd_sel_nxt;
    logic           last_bit;
    logic           other_full;
    logic           out_sel;
    logic [4:0]     p_cur;
    logic [BB-1:0]  bit_sel;
    logic [Tw*Ti-1:0] bits;

    assign o_ready  = !reset && !full[wr_sel];
    assign accept   = i_valid && o_ready;
    assign last_win = (wcnt == WB'(Tw - 1));
    assign p_cur    = prec[rd_sel];

    // Fill pointers; precision of a brick is captured with its first window
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_sel  <= 1'b0;
            wcnt    <= '0;
            prec[0] <= '0;
            prec[1] <= '0;
        end else if (accept) begin
            if (wcnt == '0)
                prec[wr_sel] <= (i_precision == 5'd0 || i_precision > P_MAX) ? P_MAX : i_precision;
            if (last_win) begin
                wcnt   <= '0;
                wr_sel <= ~wr_sel;
            end else begin
                wcnt <= wcnt + 1'b1;
            end
        end
    end

    // Window storage; contents of a freed buffer are simply overwritten
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < Ti; i++)
                mem[wr_sel][wcnt][i] <= i_window[N*i +: N];
        end
    end

    // Full flags: the replayed buffer is released at the edge that ends its o_load cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 2'b00;
        end else begin
            if (o_load[0])
                full[out_sel] <= 1'b0;
            if (accept && last_win)
                full[wr_sel] <= 1'b1;
        end
    end

    // Replay state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            k      <= '0;
            rd_sel <= 1'b0;
        end else begin
            state  <= state_nxt;
            k      <= k_nxt;
            rd_sel <= rd_sel_nxt;
        end
    end

    // Replay next-state: a brick pending release still shows full, so it is masked out
    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        rd_sel_nxt = rd_sel;
        last_bit   = 1'b0;
        other_full = full[~rd_sel] && !(o_load[0] && (out_sel == ~rd_sel));
        case (state)
            IDLE: begin
                if (full[rd_sel]) begin
                    state_nxt = SERIAL;
                    k_nxt     = '0;
                end
            end
            SERIAL: begin
                if (k == p_cur - 5'd1) begin
                    last_bit   = 1'b1;
                    rd_sel_nxt = ~rd_sel;
                    k_nxt      = '0;
                    state_nxt  = other_full ? SERIAL : IDLE;
                end else begin
                    k_nxt = k + 5'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit slice for the current cycle: bit p-1-k of every neuron of every window
    always_comb begin
        bits    = '0;
        bit_sel = BB'(p_cur - 5'd1 - k);
        for (int w = 0; w < Tw; w++)
            for (int i = 0; i < Ti; i++)
                bits[w*Ti+i] = mem[rd_sel][w][i][bit_sel];
    end

    // Registered slice outputs; data and precision hold outside bit cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid       <= 1'b0;
            o_first_cycle <= 1'b0;
            o_load        <= '0;
            o_inputs      <= '0;
            o_precision   <= '0;
            out_sel       <= 1'b0;
        end else begin
            o_valid       <= (state == SERIAL);
            o_first_cycle <= (state == SERIAL) && (k == 5'd0);
            o_load        <= {Tw{last_bit}};
            if (state == SERIAL) begin
                o_inputs    <= bits;
                o_precision <= p_cur;
                out_sel     <= rd_sel;
            end
        end
    end

endmodule

// File: tb/tb_stripes_input_serializer.sv
// tb/tb_stripes_input_serializer.sv - randomized scoreboard bench for stripes_input_serializer
module tb_stripes_input_serializer;

    localparam int N  = 16;
    localparam int Ti = 16;
    localparam int Tw = 16;
    localparam int WW = N * Ti;
    localparam int OW = Tw * Ti;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_valid;
    logic          o_ready;
    logic [WW-1:0] i_window;
    logic [4:0]    i_precision;
    logic [OW-1:0] o_inputs;
    logic          o_valid;
    logic          o_first_cycle;
    logic [Tw-1:0] o_load;
    logic [4:0]    o_precision;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [WW-1:0] exp_win [$];
    int            exp_p [$];
    logic [WW-1:0] cur [Tw];
    logic [WW-1:0] stage [Tw];
    bit            have = 0;
    int            mk = 0;
    int            mp = 0;
    int            first_log [$];
    int            load_log [$];
    int            acc_log [$];
    int            wait_log [$];
    int            n_valid = 0;

    stripes_input_serializer dut (
        .clk           (clk),
        .reset         (reset),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_window      (i_window),
        .i_precision   (i_precision),
        .o_inputs      (o_inputs),
        .o_valid       (o_valid),
        .o_first_cycle (o_first_cycle),
        .o_load        (o_load),
        .o_precision   (o_precision)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] model_bits(input int b);
        logic [OW-1:0] v;
        v = '0;
        for (int w = 0; w < Tw; w++)
            for (int i = 0; i < Ti; i++)
                v[w*Ti+i] = cur[w][N*i+b];
        return v;
    endfunction

    function automatic int peff_of(input logic [4:0] p);
        return (p == 0 || p > 16) ? 16 : int'(p);
    endfunction

    // Scoreboard: each brick must appear as p consecutive bit cycles, MSB first
    always @(negedge clk) begin
        logic [Tw-1:0] exp_load;
        if (reset) begin
            exp_win.delete();
            exp_p.delete();
            have = 0;
        end else if (o_valid) begin
            if (o_first_cycle) first_log.push_back(cyc);
            if (o_load[0]) load_log.push_back(cyc);
            n_valid++;
            if (!have) begin
                if (exp_p.size() == 0) begin
                    check("unexpected_valid", o_valid, 1'b0);
                end else begin
                    mp = exp_p.pop_front();
                    for (int w = 0; w < Tw; w++) cur[w] = exp_win.pop_front();
                    have = 1;
                    mk = 0;
                end
            end
            if (have) begin
                exp_load = (mk == mp - 1) ? {Tw{1'b1}} : {Tw{1'b0}};
                check("bits", o_inputs, model_bits(mp - 1 - mk));
                check("first_cycle", o_first_cycle, mk == 0);
                check("load", o_load, exp_load);
                check("precision", o_precision, mp);
                mk++;
                if (mk == mp) have = 0;
            end
        end else if (have) begin
            check("valid_gap", o_valid, 1'b1);
            have = 0;
        end
    end

    task automatic clear_logs();
        first_log.delete();
        load_log.delete();
        acc_log.delete();
        wait_log.delete();
        n_valid = 0;
    endtask

    task automatic rand_stage();
        for (int w = 0; w < Tw; w++)
            for (int j = 0; j < WW / 32; j++)
                stage[w][32*j +: 32] = $urandom();
    endtask

    // Entered just after a negedge; returns just after the negedge following the accept
    task automatic send_window(input logic [WW-1:0] data, input logic [4:0] p, input bit gaps);
        int waited;
        waited = 0;
        if (gaps) begin
            while ($urandom_range(1) == 0) begin
                i_valid = 1'b0;
                @(negedge clk);
            end
        end
        i_valid     = 1'b1;
        i_window    = data;
        i_precision = p;
        while (!o_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", o_ready, 1'b1);
        acc_log.push_back(cyc + 1);
        wait_log.push_back(waited);
        @(negedge clk);
    endtask

    task automatic send_brick(input logic [4:0] p, input bit gaps);
        for (int w = 0; w < Tw; w++) send_window(stage[w], p, gaps);
        for (int w = 0; w < Tw; w++) exp_win.push_back(stage[w]);
        exp_p.push_back(peff_of(p));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_p.size() != 0 || have || o_valid) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", n < 600, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int last;
        int tot;
        logic [4:0] p;
        logic [4:0] plist [3];

        reset = 1'b1;
        i_valid = 1'b0;
        i_window = '0;
        i_precision = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", o_ready, 1'b0);
        check("rst_valid", o_valid, 1'b0);
        check("rst_first", o_first_cycle, 1'b0);
        check("rst_load", o_load, '0);
        check("rst_inputs", o_inputs, '0);
        check("rst_precision", o_precision, '0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", o_ready, 1'b1);

        // 16'h8001 everywhere at full precision
        clear_logs();
        for (int w = 0; w < Tw; w++) stage[w] = {Ti{16'h8001}};
        send_brick(5'd16, 1'b0);
        i_valid = 1'b0;
        last = acc_log[acc_log.size()-1];
        wait_idle();
        check("t1_latency", first_log[0] - last, 2);
        check("t1_valid_cnt", n_valid, 16);
        check("t1_firsts", first_log.size(), 1);
        check("t1_load_pos", load_log[0] - first_log[0], 15);

        // Low-byte-zero pattern at 8, 0 and 20 bits
        plist[0] = 5'd8; plist[1] = 5'd0; plist[2] = 5'd20;
        for (int t = 0; t < 3; t++) begin
            clear_logs();
            for (int w = 0; w < Tw; w++)
                for (int i = 0; i < Ti; i++)
                    stage[w][N*i +: N] = {4'(w), 4'(i), 8'h00};
            send_brick(plist[t], 1'b0);
            i_valid = 1'b0;
            wait_idle();
            check("t2_valid_cnt", n_valid, peff_of(plist[t]));
        end

        // Two short bricks with continuous i_valid
        clear_logs();
        rand_stage();
        send_brick(5'd4, 1'b0);
        rand_stage();
        send_brick(5'd4, 1'b0);
        i_valid = 1'b0;
        wait_idle();
        check("t3_firsts", first_log.size(), 2);
        check("t3_valid_cnt", n_valid, 8);
        check("t3_second_latency", first_log[1] - acc_log[31], 2);

        // Three full-precision bricks: backpressure and gapless handover
        clear_logs();
        for (int b = 0; b < 3; b++) begin
            rand_stage();
            send_brick(5'd16, 1'b0);
        end
        i_valid = 1'b0;
        wait_idle();
        check("t4_first32_contig", acc_log[31] - acc_log[0], 31);
        check("t4_ready_dropped", wait_log[32] != 0, 1'b1);
        check("t4_ready_rise", acc_log[32], load_log[0] + 2);
        check("t4_back_to_back", first_log[1], load_log[0] + 1);
        check("t4_valid_cnt", n_valid, 48);
        check("t4_firsts", first_log.size(), 3);

        // Random data, random precision, 50% input bubbles
        clear_logs();
        tot = 0;
        for (int b = 0; b < 4; b++) begin
            rand_stage();
            p = 5'($urandom_range(20));
            tot += peff_of(p);
            send_brick(p, 1'b1);
        end
        i_valid = 1'b0;
        wait_idle();
        check("t5_valid_cnt", n_valid, tot);
        check("t5_firsts", first_log.size(), 4);

        // Reset during bit cycle 5 with a partial second brick
        clear_logs();
        rand_stage();
        send_brick(5'd16, 1'b0);
        rand_stage();
        for (int w = 0; w < 6; w++) send_window(stage[w], 5'd16, 1'b0);
        i_valid = 1'b0;
        @(negedge clk);
        check("t6_bit5_valid", o_valid, 1'b1);
        check("t6_bit5_notfirst", o_first_cycle, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", o_valid, 1'b0);
        check("t6_rst_ready", o_ready, 1'b0);
        check("t6_rst_load", o_load, '0);
        reset = 1'b0;
        @(negedge clk);
        check("t6_ready_after", o_ready, 1'b1);
        clear_logs();
        repeat (40) @(negedge clk);
        check("t6_quiet", n_valid, 0);
        rand_stage();
        p = 5'($urandom_range(1, 16));
        send_brick(p, 1'b0);
        i_valid = 1'b0;
        wait_idle();
        check("t6_fresh_firsts", first_log.size(), 1);
        check("t6_fresh_cnt", n_valid, peff_of(p));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
